capture_8seg: RTL and testbench

Passive capture block for a multiplexed 8-segment LED display bus. It reverses the hex-to-segment decoding: it samples the segment lines and one-hot digit-select lines driven by an external or on-chip display scanner, waits for them to settle, and converts each digit's segment pattern back to a 4-bit hex value plus dot. The result is a per-digit register file readable by the MCU side, so the CPU can read back or self-test what is shown on the display.

---
 rtl/capture_8seg_if.sv | 28 ++
 rtl/capture_8seg.sv | 208 ++++++++++++++++++++
 tb/tb_capture_8seg.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/capture_8seg_if.sv
// ----------------------------------------------------------------------------
// capture_8seg_if
//   Multiplexed 8-segment display bus as seen by a passive observer.
//
//   Signals:
//     leds_val  [7:0]         segment lines {dot, g, f, e, d, c, b, a}, active-high
//     dig_sel   [DIGITS-1:0]  digit enables, active-high, one-hot while driven
//
//   Modports:
//     master  the display scanner that drives the bus
//     slave   a listener (capture_8seg) that only samples the bus
// ----------------------------------------------------------------------------
interface capture_8seg_if #(
    parameter int DIGITS = 4
);
    logic [7:0]        leds_val;
    logic [DIGITS-1:0] dig_sel;

    modport master (
        output leds_val,
        output dig_sel
    );

    modport slave (
        input leds_val,
        input dig_sel
    );
endinterface

// File: rtl/capture_8seg.sv
// ----------------------------------------------------------------------------
// capture_8seg
//   Passive capture of a multiplexed 8-segment LED display bus. The segment
//   and digit-select lines are synchronized, required to hold steady for
//   STABLE consecutive samples, and the addressed digit's segment pattern is
//   decoded back to a hex value plus dot into a per-digit register file.
//
//   Parameters:
//     DIGITS  number of multiplexed digits (1..8)
//     STABLE  consecutive identical synchronized samples before commit (2..15)
//
//   Ports:
//     clk       system clock
//     rst_n     asynchronous active-low reset
//     bus       display bus (slave modport): leds_val, dig_sel, async to clk
//     tetrades  captured hex value, digit i at [4i+3:4i]
//     dots      captured dot bit per digit
//     blank     1 = last committed pattern for the digit had all segments off
//     bad       1 = last committed pattern for the digit was not a hex glyph
//     upd       one-cycle pulse when any digit's stored fields change
// ----------------------------------------------------------------------------
module capture_8seg #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    capture_8seg_if.slave         bus,
    output logic [4*DIGITS-1:0]   tetrades,
    output logic [DIGITS-1:0]     dots,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     bad,
    output logic                  upd
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE - 1);

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        COMMIT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Returns {hit, code}; hit is 0 when the pattern is not an exact hex glyph.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    function automatic logic is_onehot(input logic [DIGITS-1:0] v);
        return (v != '0) && ((v & (v - DIGITS'(1))) == '0);
    endfunction

    // Synchronizers, previous-sample register, stability counter
    logic [7:0]        leds_m_q, leds_s_q, leds_p_q;
    logic [DIGITS-1:0] sel_m_q,  sel_s_q,  sel_p_q;
    logic [3:0]        cnt_q, cnt_d;
    logic              chg;

    // Captured register file
    logic [4*DIGITS-1:0] tet_q,   tet_d;
    logic [DIGITS-1:0]   dots_q,  dots_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [DIGITS-1:0]   bad_q,   bad_d;
    logic                upd_q,   upd_d;

    state_t state_q, state_d;
    logic [4:0] dec;

    // ---- stage: 2-flop synchronizers and previous-sample capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_m_q <= '0;
            leds_s_q <= '0;
            leds_p_q <= '0;
            sel_m_q  <= '0;
            sel_s_q  <= '0;
            sel_p_q  <= '0;
            cnt_q    <= '0;
        end else begin
            leds_m_q <= bus.leds_val;
            leds_s_q <= leds_m_q;
            leds_p_q <= leds_s_q;
            sel_m_q  <= bus.dig_sel;
            sel_s_q  <= sel_m_q;
            sel_p_q  <= sel_s_q;
            cnt_q    <= cnt_d;
        end
    end

    // Segment and select are one event: any difference restarts the window.
    assign chg = ({sel_s_q, leds_s_q} != {sel_p_q, leds_p_q});

    always_comb begin
        cnt_d = cnt_q;
        if (chg) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // ---- stage: settle / commit / hold control ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The counter's next value is used so the window closes on the edge it
    // becomes full; the write then happens on the following edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SETTLE: begin
                if (cnt_d == CNT_MAX) begin
                    state_d = is_onehot(sel_s_q) ? COMMIT : HOLD;
                end
            end
            COMMIT: begin
                // A change arriving during the write cycle opens a new window.
                state_d = chg ? SETTLE : HOLD;
            end
            HOLD: begin
                if (chg) begin
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    // ---- stage: decode and register-file write ----
    // In COMMIT the previous-sample register holds the value that was
    // verified stable, so it is used rather than the live synchronizer.
    always_comb begin
        tet_d   = tet_q;
        dots_d  = dots_q;
        blank_d = blank_q;
        bad_d   = bad_q;
        dec     = seg_decode(leds_p_q[6:0]);
        if (state_q == COMMIT) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sel_p_q[i]) begin
                    dots_d[i] = leds_p_q[7];
                    if (dec[4]) begin
                        tet_d[4*i +: 4] = dec[3:0];
                        blank_d[i]      = 1'b0;
                        bad_d[i]        = 1'b0;
                    end else if (leds_p_q[6:0] == 7'h00) begin
                        tet_d[4*i +: 4] = 4'h0;
                        blank_d[i]      = 1'b1;
                        bad_d[i]        = 1'b0;
                    end else begin
                        blank_d[i]      = 1'b0;
                        bad_d[i]        = 1'b1;
                    end
                end
            end
        end
        upd_d = (state_q == COMMIT) &&
                ({tet_d, dots_d, blank_d, bad_d} != {tet_q, dots_q, blank_q, bad_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tet_q   <= '0;
            dots_q  <= '0;
            blank_q <= '1;
            bad_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            tet_q   <= tet_d;
            dots_q  <= dots_d;
            blank_q <= blank_d;
            bad_q   <= bad_d;
            upd_q   <= upd_d;
        end
    end

    assign tetrades = tet_q;
    assign dots     = dots_q;
    assign blank    = blank_q;
    assign bad      = bad_q;
    assign upd      = upd_q;

endmodule

// File: tb/tb_capture_8seg.sv
// ----------------------------------------------------------------------------
// tb_capture_8seg
//   Directed bench for capture_8seg with DIGITS=4, STABLE=3. Inputs change on
//   the falling edge; outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_capture_8seg;

    logic        clk;
    logic        rst_n;
    logic [15:0] tetrades;
    logic [3:0]  dots;
    logic [3:0]  blank;
    logic [3:0]  bad;
    logic        upd;

    int checks  = 0;
    int errors  = 0;
    int upd_cnt = 0;

    capture_8seg_if #(.DIGITS(4)) bus ();

    capture_8seg #(
        .DIGITS(4),
        .STABLE(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .tetrades (tetrades),
        .dots     (dots),
        .blank    (blank),
        .bad      (bad),
        .upd      (upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [7:0] leds);
        @(negedge clk);
        bus.dig_sel  = sel;
        bus.leds_val = leds;
    endtask

    // Advance n rising edges, counting upd pulses seen after each edge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (upd === 1'b1) upd_cnt++;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.dig_sel  = 4'b0000;
        bus.leds_val = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(6);

        // Reset state, bus idle after release commits nothing
        chk("rst_tetrades", 32'(tetrades), 32'h0000);
        chk("rst_dots",     32'(dots),     32'h0);
        chk("rst_blank",    32'(blank),    32'hF);
        chk("rst_bad",      32'(bad),      32'h0);
        chk("rst_upd",      32'(upd),      32'h0);

        // Static digit 1 with "2." : commit on edge 6 after the change
        upd_cnt = 0;
        drive(4'b0010, 8'hDB);
        run(5);
        chk("static_upd_early", 32'(upd_cnt),  32'd0);
        chk("static_tet_early", 32'(tetrades), 32'h0000);
        run(1);
        chk("static_upd_edge6", 32'(upd),      32'h1);
        chk("static_tetrades",  32'(tetrades), 32'h0020);
        chk("static_dots",      32'(dots),     32'b0010);
        chk("static_blank",     32'(blank),    32'b1101);
        run(4);
        chk("static_upd_once",  32'(upd_cnt),  32'd1);

        // Full scan 0,1,A,F then repeat
        upd_cnt = 0;
        drive(4'b0001, 8'h3F); run(8);
        drive(4'b0010, 8'h06); run(8);
        drive(4'b0100, 8'h77); run(8);
        drive(4'b1000, 8'h71); run(8);
        chk("scan_tetrades", 32'(tetrades), 32'hFA10);
        chk("scan_dots",     32'(dots),     32'h0);
        chk("scan_blank",    32'(blank),    32'h0);
        chk("scan_bad",      32'(bad),      32'h0);
        chk("scan_upd_cnt",  32'(upd_cnt),  32'd4);
        upd_cnt = 0;
        drive(4'b0001, 8'h3F); run(8);
        drive(4'b0010, 8'h06); run(8);
        drive(4'b0100, 8'h77); run(8);
        drive(4'b1000, 8'h71); run(8);
        chk("rescan_upd_cnt",  32'(upd_cnt),  32'd0);
        chk("rescan_tetrades", 32'(tetrades), 32'hFA10);

        // Glitch: digit 0 holds "1", a 2-cycle "8" must not commit
        upd_cnt = 0;
        drive(4'b0001, 8'h06); run(8);
        chk("glitch_setup_tet", 32'(tetrades), 32'hFA11);
        chk("glitch_setup_upd", 32'(upd_cnt),  32'd1);
        upd_cnt = 0;
        drive(4'b0001, 8'h7F); run(2);
        drive(4'b0001, 8'h06); run(10);
        chk("glitch_tet",     32'(tetrades[3:0]), 32'h1);
        chk("glitch_upd_cnt", 32'(upd_cnt),       32'd0);

        // Invalid glyph keeps the tetrade, then all-off blanks it
        upd_cnt = 0;
        drive(4'b1000, 8'h27); run(8);
        chk("bad_tetrades", 32'(tetrades), 32'hFA11);
        chk("bad_bad",      32'(bad),      32'b1000);
        chk("bad_blank",    32'(blank),    32'b0000);
        drive(4'b1000, 8'h00); run(8);
        chk("blank_tetrades", 32'(tetrades), 32'h0A11);
        chk("blank_blank",    32'(blank),    32'b1000);
        chk("blank_bad",      32'(bad),      32'b0000);
        chk("inv_upd_cnt",    32'(upd_cnt),  32'd2);

        // Select errors: multi-hot and none
        upd_cnt = 0;
        drive(4'b0110, 8'hFF); run(20);
        drive(4'b0000, 8'h5B); run(20);
        chk("sel_upd_cnt",  32'(upd_cnt),  32'd0);
        chk("sel_tetrades", 32'(tetrades), 32'h0A11);
        chk("sel_dots",     32'(dots),     32'h0);
        chk("sel_blank",    32'(blank),    32'b1000);
        chk("sel_bad",      32'(bad),      32'h0);

        // Reset asserted in the COMMIT cycle of a pending "8" on digit 0
        drive(4'b0001, 8'h7F);
        run(5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tetrades", 32'(tetrades), 32'h0000);
        chk("mid_rst_dots",     32'(dots),     32'h0);
        chk("mid_rst_blank",    32'(blank),    32'hF);
        chk("mid_rst_bad",      32'(bad),      32'h0);
        chk("mid_rst_upd",      32'(upd),      32'h0);
        run(2);
        chk("in_rst_tetrades",  32'(tetrades), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        upd_cnt = 0;
        run(8);
        chk("post_rst_tetrades", 32'(tetrades), 32'h0008);
        chk("post_rst_blank",    32'(blank),    32'b1110);
        chk("post_rst_upd_cnt",  32'(upd_cnt),  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
